// File: rtl/choco_dispenser.sv
// Downstream stage of the chocolate vending FSM: queues one-hot item requests, drives one motor
// per vend, confirms each drop with a sensor timeout, and tracks per-item stock.
module choco_dispenser #(
  parameter int unsigned MOTOR_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned STOCK_INIT     = 15,
  parameter int unsigned STOCK_W        = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_chocolate,
  input  logic       i_drop_sensor,
  input  logic       i_refill,
  output logic [2:0] o_motor,
  output logic       o_busy,
  output logic       o_fault,
  output logic       o_reject,
  output logic       o_vend_done,
  output logic       o_fifo_full,
  output logic [2:0] o_stock_empty
);

  localparam int unsigned TimerMax =
    (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = $clog2(TimerMax + 1);

  localparam logic [TimerW-1:0]  MotorLoad   = TimerW'(MOTOR_CYCLES);
  localparam logic [TimerW-1:0]  TimeoutLoad = TimerW'(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0]  TimerOne    = TimerW'(1);
  localparam logic [STOCK_W-1:0] StockLoad   = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] StockOne    = STOCK_W'(1);

  typedef enum logic [1:0] {StIdle, StSpin, StWaitDrop, StFault} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [TimerW-1:0]   r_timer;
  logic [TimerW-1:0]   w_timer_d;
  logic [1:0]          r_item;
  logic [1:0]          w_item_d;
  logic                r_reject;
  logic                r_vend_done;
  logic                w_vend_done_d;

  logic [1:0]          r_mem [4];
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_count;

  logic [STOCK_W-1:0]  r_stock      [3];
  logic [STOCK_W-1:0]  w_stock_eff  [3];
  logic [STOCK_W-1:0]  w_stock_next [3];
  logic [STOCK_W-1:0]  w_sel_stock;

  logic                w_req_any;
  logic                w_multi;
  logic [1:0]          w_code;
  logic                w_full;
  logic                w_push;
  logic                w_reject;
  logic                w_pop;

  // ---------------------------------------------------------------------------
  // Input acceptance
  // ---------------------------------------------------------------------------
  assign w_req_any = |i_chocolate;
  assign w_multi   = (i_chocolate & (i_chocolate - 3'd1)) != 3'd0;
  assign w_full    = (r_count == 3'd4);

  always_comb begin
    w_code = 2'd0;
    if (i_chocolate[0]) begin
      w_code = 2'd0;
    end else if (i_chocolate[1]) begin
      w_code = 2'd1;
    end else if (i_chocolate[2]) begin
      w_code = 2'd2;
    end
  end

  // A same-cycle refill is applied before the request is judged against stock.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_stock_eff[i] = i_refill ? StockLoad : r_stock[i];
    end
  end

  always_comb begin
    unique case (w_code)
      2'd0:    w_sel_stock = w_stock_eff[0];
      2'd1:    w_sel_stock = w_stock_eff[1];
      default: w_sel_stock = w_stock_eff[2];
    endcase
  end

  assign w_push   = w_req_any && !w_multi && !w_full && (w_sel_stock != '0);
  assign w_reject = w_req_any && !w_push;
  assign w_pop    = (r_state == StIdle) && (r_count != 3'd0);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_stock_next[i] = w_stock_eff[i];
      if (w_push && (w_code == 2'(i))) begin
        w_stock_next[i] = w_stock_eff[i] - StockOne;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_stock[i] <= StockLoad;
      end
      r_reject <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_stock[i] <= w_stock_next[i];
      end
      r_reject <= w_reject;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FIFO, four entries, no bypass
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 2'd0;
      end
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_code;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Vend FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d     = r_state;
    w_timer_d     = r_timer;
    w_item_d      = r_item;
    w_vend_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_state_d = StSpin;
          w_timer_d = MotorLoad;
          w_item_d  = r_mem[r_rd_ptr];
        end
      end
      StSpin: begin
        if (r_timer == TimerOne) begin
          w_state_d = StWaitDrop;
          w_timer_d = TimeoutLoad;
        end else begin
          w_timer_d = r_timer - TimerOne;
        end
      end
      StWaitDrop: begin
        if (i_drop_sensor) begin
          w_state_d     = StIdle;
          w_timer_d     = '0;
          w_vend_done_d = 1'b1;
        end else if (r_timer == TimerOne) begin
          w_state_d = StFault;
          w_timer_d = '0;
        end else begin
          w_timer_d = r_timer - TimerOne;
        end
      end
      StFault: begin
        if (i_refill) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_item      <= 2'd0;
      r_vend_done <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_timer     <= w_timer_d;
      r_item      <= w_item_d;
      r_vend_done <= w_vend_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    o_motor = 3'b000;
    if (r_state == StSpin) begin
      o_motor = 3'b001 << r_item;
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_fault     = (r_state == StFault);
  assign o_reject    = r_reject;
  assign o_vend_done = r_vend_done;
  assign o_fifo_full = w_full;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      o_stock_empty[i] = (r_stock[i] == '0);
    end
  end

endmodule

// File: tb/tb_choco_dispenser.sv
// Self-checking bench for choco_dispenser: table-driven acceptance vectors, a queue of expected
// dispensed items checked against motor activity, and hand sequences for timeout/refill/reset.
module tb_choco_dispenser;

  localparam int Motor   = 8;
  localparam int Timeout = 32;
  localparam int SInit   = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] choc = 3'b000;
  logic       drop = 1'b0;
  logic       refill = 1'b0;
  logic [2:0] motor;
  logic       busy;
  logic       fault;
  logic       rej;
  logic       vend_done;
  logic       full;
  logic [2:0] stock_empty;

  choco_dispenser #(
    .MOTOR_CYCLES  (Motor),
    .TIMEOUT_CYCLES(Timeout),
    .STOCK_INIT    (SInit),
    .STOCK_W       (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_chocolate  (choc),
    .i_drop_sensor(drop),
    .i_refill     (refill),
    .o_motor      (motor),
    .o_busy       (busy),
    .o_fault      (fault),
    .o_reject     (rej),
    .o_vend_done  (vend_done),
    .o_fifo_full  (full),
    .o_stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  typedef struct {
    logic [2:0] choc;
    logic       exp_reject;
    logic       exp_full;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int item_code(input logic [2:0] c);
    if (c[0]) return 0;
    if (c[1]) return 1;
    return 2;
  endfunction

  // Scoreboard: each motor run must match the next accepted item and last exactly Motor cycles.
  logic [2:0] prev_motor = 3'b000;
  int         run_len = 0;
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      run_len    = 0;
      prev_motor = 3'b000;
    end else begin
      if (motor != 3'b000) begin
        if (prev_motor == 3'b000) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL motor_start: got motor=%b expected no vend", motor);
          end else begin
            e = exp_q.pop_front();
            check("motor_item", int'(motor), 1 << e);
          end
        end
        run_len++;
      end else if (run_len != 0) begin
        check("motor_len", run_len, Motor);
        run_len = 0;
      end
      prev_motor = motor;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] c, input logic exp_rej, input string name);
    if (!exp_rej) exp_q.push_back(item_code(c));
    choc = c;
    step();
    choc = 3'b000;
    check({name, "_reject"}, int'(rej), int'(exp_rej));
  endtask

  task automatic wait_motor(input logic on, input string name);
    int n = 0;
    while (((motor != 3'b000) != on) && n < 40) begin
      step();
      n++;
    end
    check(name, int'(motor != 3'b000), int'(on));
  endtask

  // One full vend with the drop arriving three cycles after the motor stops.
  task automatic vend_one(input string name);
    wait_motor(1'b1, {name, "_motor_on"});
    wait_motor(1'b0, {name, "_motor_off"});
    step();
    step();
    drop = 1'b1;
    step();
    drop = 1'b0;
    check({name, "_vend_done"}, int'(vend_done), 1);
    check({name, "_idle"}, int'(busy), 0);
    step();
    check({name, "_vend_done_pulse"}, int'(vend_done), 0);
  endtask

  initial begin
    vecs[0] = '{3'b001, 1'b0, 1'b0};
    vecs[1] = '{3'b010, 1'b0, 1'b0};
    vecs[2] = '{3'b100, 1'b0, 1'b0};
    vecs[3] = '{3'b001, 1'b0, 1'b0};
    vecs[4] = '{3'b010, 1'b0, 1'b1};
    vecs[5] = '{3'b100, 1'b1, 1'b1};
    vecs[6] = '{3'b011, 1'b1, 1'b1};

    // Reset state
    step();
    step();
    check("rst_motor", int'(motor), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_reject", int'(rej), 0);
    check("rst_vend_done", int'(vend_done), 0);
    check("rst_full", int'(full), 0);
    check("rst_stock_empty", int'(stock_empty), 0);
    rst_n = 1'b1;
    step();

    // Single vend of item 1
    request(3'b010, 1'b0, "t1_req");
    vend_one("t1");
    check("t1_stock1", int'(dut.r_stock[1]), SInit - 1);

    // Five back-to-back requests fill the FIFO; sixth and a multi-hot request are rejected
    for (int i = 0; i < 7; i++) begin
      request(vecs[i].choc, vecs[i].exp_reject, $sformatf("t2_vec%0d", i));
      check($sformatf("t2_vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
    end
    for (int i = 0; i < 5; i++) begin
      vend_one($sformatf("t2_drain%0d", i));
    end
    check("t2_stock_empty", int'(stock_empty), 0);

    // Timeout fault, request queued while faulted, refill recovers
    request(3'b100, 1'b0, "t3_req");
    wait_motor(1'b1, "t3_motor_on");
    wait_motor(1'b0, "t3_motor_off");
    for (int i = 0; i < Timeout - 1; i++) step();
    check("t3_no_fault_early", int'(fault), 0);
    step();
    check("t3_fault", int'(fault), 1);
    check("t3_fault_motor", int'(motor), 0);
    request(3'b001, 1'b0, "t3_req_in_fault");
    step();
    step();
    check("t3_fault_no_pop", int'(motor), 0);
    check("t3_fault_held", int'(fault), 1);
    refill = 1'b1;
    step();
    refill = 1'b0;
    check("t3_refill_clears", int'(fault), 0);
    for (int i = 0; i < 3; i++) check($sformatf("t3_stock%0d", i), int'(dut.r_stock[i]), SInit);
    vend_one("t3_queued");

    // Drain item 0, reject when sold out, refill with simultaneous request
    for (int i = 0; i < SInit; i++) begin
      request(3'b001, 1'b0, $sformatf("t4_req%0d", i));
      vend_one($sformatf("t4_vend%0d", i));
    end
    check("t4_sold_out", int'(stock_empty), 3'b001);
    request(3'b001, 1'b1, "t4_req_empty");
    exp_q.push_back(0);
    choc   = 3'b001;
    refill = 1'b1;
    step();
    choc   = 3'b000;
    refill = 1'b0;
    check("t4_refill_req_reject", int'(rej), 0);
    check("t4_refill_stock0", int'(dut.r_stock[0]), SInit - 1);
    check("t4_refill_empty", int'(stock_empty), 0);
    vend_one("t4_refill_vend");

    // Multi-hot request: no push, no stock change
    request(3'b011, 1'b1, "t5_multi");
    step();
    step();
    check("t5_no_vend", int'(busy), 0);
    check("t5_stock0", int'(dut.r_stock[0]), SInit - 1);
    check("t5_stock1", int'(dut.r_stock[1]), SInit);

    // Asynchronous reset mid-spin
    request(3'b010, 1'b0, "t6_req");
    request(3'b100, 1'b0, "t6_req2");
    wait_motor(1'b1, "t6_motor_on");
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_motor_off", int'(motor), 0);
    step();
    check("t6_rst_count", int'(dut.r_count), 0);
    check("t6_rst_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) check($sformatf("t6_stock%0d", i), int'(dut.r_stock[i]), SInit);
    rst_n = 1'b1;
    exp_q.delete();
    step();
    step();
    check("t6_post_idle", int'(busy), 0);
    check("t6_post_motor", int'(motor), 0);
    check("t6_post_full", int'(full), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
